wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage for the five-stage MIPS pipeline: captures the M-stage instruction, PC+8, ALU result, data-memory read word and HI/LO read value into the M/W pipeline register on each clock. From the registered W-stage state it derives the register-file write port: write enable, destination index, write data and trace PC. It also extends sub-word loads. It is the producer side of the register-file write interface, and it supplies IR_W/A3_W/WData to the hazard and forwarding logic.

## Interface
- Parameters: none.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset: synchronous, active-high; clock clk. Clears the M/W register.
- clr  in  1  synchronous bubble insert; loads the same zeros as reset.
- IR_M  in  32  M-stage instruction.
- PC8_M  in  32  M-stage PC+8.
- ALUOut_M  in  32  M-stage ALU result / memory address.
- DMRead_M  in  32  aligned word read from data memory in M.
- MDOut_M  in  32  HI or LO value selected in M (mfhi/mflo).
- IR_W  out  32  registered instruction, for the hazard unit.
- PC8_W  out  32  registered PC+8.
- PC_W  out  32  PC8_W − 8, modulo 2^32, for the write trace.
- RegWrite  out  1  RF write enable.
- A3_W  out  5  RF write index.
- WData  out  32  RF write data.

## Operation
- M/W register fields: IR, PC8, ALUOut, DMRead, MDOut, all 32 bits.
- Decode uses IR_W only: op = [31:26], rt = [20:16], rd = [15:11], funct = [5:0].
- Destination selection:
  - rd when op=0 and funct ∈ {00,02,03,04,06,07,09,10,12,20,21,22,23,24,25,26,27,2a,2b}.
  - rt when op ∈ {08,09,0a,0b,0c,0d,0e,0f,20,21,23,24,25}.
  - 31 when op=03 (jal).
  - Otherwise there is no write.
- A3_W = selected index; 0 when there is no write.
- RegWrite = write-class instruction AND A3_W≠0. The nop word (IR=0) and writes to $0 therefore give RegWrite=0 and A3_W=0.
- WData selection:
  - extended load data for op ∈ {20,21,23,24,25};
  - PC8_W for jal and jalr (funct 09);
  - MDOut_W for mfhi (10) and mflo (12);
  - ALUOut_W otherwise.
- Load extension uses byte offset b = ALUOut_W[1:0], little-endian (b=0 is bits 7:0).
  - lw: the DMRead word.
  - lb / lbu: the byte at b, sign-extended / zero-extended.
  - lh / lhu: halfword ALUOut_W[1] (0 → bits 15:0), sign-extended / zero-extended. ALUOut_W[0] is ignored.
  - Misalignment is not checked here.
- WData for a non-writing instruction is whatever the data mux selects. It is don't-care, but deterministic.

## Timing
- Latency: M-stage inputs present before posedge N appear on all outputs after posedge N. There is no stall; the register loads every cycle.
- Priority at a clock edge: reset > clr > load.
- Reset and clr values: IR_W=0, PC8_W=0, PC_W=32'hFFFF_FFF8, RegWrite=0, A3_W=0, WData=0.
- All outputs are combinational from the W register only; there is no input-to-output combinational path.
- The RF writes on the same posedge that loads the next instruction. Data must be valid for a full cycle before that edge.
- Reset asserted mid-stream discards the W instruction: no RF write is issued for it.

## Configuration
- WB_LOAD_EXT_EN defined:
  - lb, lbu, lh and lhu write rt with extended data as above.
- Not defined:
  - ops 20, 21, 24 and 25 are not write-class: RegWrite=0, A3_W=0.
  - Only lw loads, and WData for a load is the raw DMRead word.
  - No byte/halfword extension logic is instantiated.

## Structure
- Shared package `mips_defs`: opcode and funct constants (OP_RTYPE, OP_JAL, OP_LW, OP_LB, …, FN_JALR, FN_MFHI, …) and the $ra index 31. The decode units in the other stages use the same constants.
- One sub-module, `load_ext`:
  - inputs: word, offset[1:0], 3-bit load-type code;
  - output: the extended word;
  - pure combinational.
  - Instantiated only under WB_LOAD_EXT_EN.

## Test plan
- Reset, then clk with IR_M=addu $3,$1,$2 and ALUOut_M=5 → after the edge: RegWrite=1, A3_W=3, WData=5. Reset asserted on the next edge → RegWrite=0, A3_W=0, WData=0, PC_W=FFFF_FFF8.
- jal with PC8_M=0000_3008 → RegWrite=1, A3_W=31, WData=0000_3008, PC_W=0000_3000.
- lw $4 with DMRead_M=8765_4321 → WData=8765_4321. With WB_LOAD_EXT_EN, using DMRead_M=8765_43F1:
  - lb, ALUOut_M[1:0]=0 → FFFF_FFF1;
  - lbu, offset 3 → 0000_0087;
  - lh, offset 2 → FFFF_8765.
- addiu $0,$0,7 and IR_M=0 → RegWrite=0, A3_W=0. mflo $9 with MDOut_M=DEAD_BEEF → A3_W=9, WData=DEAD_BEEF.
- clr and a valid addu in the same cycle → the W state is a bubble (RegWrite=0). Reset and clr together → reset values.
- Without WB_LOAD_EXT_EN: lb $5 → RegWrite=0, A3_W=0.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// rtl/mips_defs_pkg.sv - shared MIPS opcode/funct constants and load-type codes
package mips_defs;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  // Return-address register written by jal
  localparam logic [4:0] RA_IDX   = 5'd31;

  // Load-type code consumed by load_ext
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_type_e;

  // Map a load opcode onto its extension code; non-loads fall back to word
  function automatic ld_type_e ld_type_of(input logic [5:0] op);
    case (op)
      OP_LB:   return LD_B;
      OP_LBU:  return LD_BU;
      OP_LH:   return LD_H;
      OP_LHU:  return LD_HU;
      default: return LD_W;
    endcase
  endfunction

endpackage

// File: rtl/wb_stage_load_ext.sv
// rtl/wb_stage_load_ext.sv - sub-word load extension (little-endian byte lanes)
module load_ext
  import mips_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  ld_type_e    ld_type,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte lane and halfword; offset[0] is ignored for halfwords
  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  // Sign- or zero-extend the selected lane according to the load type
  always_comb begin
    ext = word;
    case (ld_type)
      LD_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   ext = {24'h000000, byte_sel};
      LD_H:    ext = {{16{half_sel[15]}}, half_sel};
      LD_HU:   ext = {16'h0000, half_sel};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - M/W pipeline register and RF write-port decode; WB_LOAD_EXT_EN enables lb/lbu/lh/lhu
module wb_stage
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic [31:0] IR_M,
  input  logic [31:0] PC8_M,
  input  logic [31:0] ALUOut_M,
  input  logic [31:0] DMRead_M,
  input  logic [31:0] MDOut_M,
  output logic [31:0] IR_W,
  output logic [31:0] PC8_W,
  output logic [31:0] PC_W,
  output logic        RegWrite,
  output logic [4:0]  A3_W,
  output logic [31:0] WData
);

  logic [31:0] alu_w;
  logic [31:0] dm_w;
  logic [31:0] md_w;

  // M/W register: reset and clr both load a bubble, otherwise load every cycle
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      IR_W  <= 32'h0;
      PC8_W <= 32'h0;
      alu_w <= 32'h0;
      dm_w  <= 32'h0;
      md_w  <= 32'h0;
    end else begin
      IR_W  <= IR_M;
      PC8_W <= PC8_M;
      alu_w <= ALUOut_M;
      dm_w  <= DMRead_M;
      md_w  <= MDOut_M;
    end
  end

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        rd_class;
  logic        rt_class;
  logic        is_jal;
  logic        is_jalr;
  logic        is_mf;
  logic        is_load;
  logic [4:0]  dest;
  logic [31:0] load_data;

  assign op    = IR_W[31:26];
  assign rt    = IR_W[20:16];
  assign rd    = IR_W[15:11];
  assign funct = IR_W[5:0];

  // Classify the W instruction by which register field (if any) it writes
  always_comb begin
    rd_class = (op == OP_RTYPE) &&
               (funct inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                              FN_JALR, FN_MFHI, FN_MFLO, FN_ADD, FN_ADDU, FN_SUB,
                              FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU});
`ifdef WB_LOAD_EXT_EN
    is_load  = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
`else
    is_load  = (op == OP_LW);
`endif
    rt_class = is_load ||
               (op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                           OP_ANDI, OP_ORI, OP_XORI, OP_LUI});
    is_jal   = (op == OP_JAL);
    is_jalr  = (op == OP_RTYPE) && (funct == FN_JALR);
    is_mf    = (op == OP_RTYPE) && ((funct == FN_MFHI) || (funct == FN_MFLO));
  end

  // Destination index; jal wins because its rt/rd fields are jump-target bits
  always_comb begin
    dest = 5'd0;
    if (is_jal)        dest = RA_IDX;
    else if (rd_class) dest = rd;
    else if (rt_class) dest = rt;
  end

  // Writes to $0 are suppressed so the hazard unit never sees A3_W=0 with RegWrite
  assign RegWrite = (dest != 5'd0);
  assign A3_W     = dest;

`ifdef WB_LOAD_EXT_EN
  load_ext u_load_ext (
    .word    (dm_w),
    .offset  (alu_w[1:0]),
    .ld_type (ld_type_of(op)),
    .ext     (load_data)
  );
`else
  assign load_data = dm_w;
`endif

  // Write-data mux; non-writing instructions fall through to the ALU result
  always_comb begin
    WData = alu_w;
    if (is_load)                WData = load_data;
    else if (is_jal || is_jalr) WData = PC8_W;
    else if (is_mf)             WData = md_w;
  end

  assign PC_W = PC8_W - 32'd8;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - table-driven and randomized checks of wb_stage
module tb_wb_stage;

`ifdef WB_LOAD_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, clr;
  logic [31:0] IR_M, PC8_M, ALUOut_M, DMRead_M, MDOut_M;
  logic [31:0] IR_W, PC8_W, PC_W, WData;
  logic        RegWrite;
  logic [4:0]  A3_W;

  int passed = 0;
  int total  = 0;

  wb_stage dut (
    .clk(clk), .reset(reset), .clr(clr),
    .IR_M(IR_M), .PC8_M(PC8_M), .ALUOut_M(ALUOut_M), .DMRead_M(DMRead_M), .MDOut_M(MDOut_M),
    .IR_W(IR_W), .PC8_W(PC8_W), .PC_W(PC_W), .RegWrite(RegWrite), .A3_W(A3_W), .WData(WData)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        clr;
    logic [31:0] ir;
    logic [31:0] pc8;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [31:0] md;
    logic        exp_rw;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd;
    logic        wd_care;
    logic [31:0] exp_pcw;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic add(input string n, input logic r, input logic c, input logic [31:0] ir,
                     input logic [31:0] pc8, input logic [31:0] alu, input logic [31:0] dm,
                     input logic [31:0] md, input logic rw, input logic [4:0] a3,
                     input logic [31:0] wd, input logic care);
    vec_t v;
    v.name = n; v.rst = r; v.clr = c; v.ir = ir; v.pc8 = pc8; v.alu = alu; v.dm = dm; v.md = md;
    v.exp_rw = rw; v.exp_a3 = a3; v.exp_wd = wd; v.wd_care = care;
    v.exp_pcw = (r || c) ? 32'hFFFF_FFF8 : pc8 - 32'd8;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, clock it in, and compare the registered outputs
  task automatic run(input vec_t v);
    reset = v.rst; clr = v.clr; IR_M = v.ir; PC8_M = v.pc8;
    ALUOut_M = v.alu; DMRead_M = v.dm; MDOut_M = v.md;
    @(posedge clk); #1;
    chk({v.name, ".RegWrite"}, {31'd0, RegWrite}, {31'd0, v.exp_rw});
    chk({v.name, ".A3_W"}, {27'd0, A3_W}, {27'd0, v.exp_a3});
    chk({v.name, ".PC_W"}, PC_W, v.exp_pcw);
    chk({v.name, ".IR_W"}, IR_W, (v.rst || v.clr) ? 32'h0 : v.ir);
    if (v.wd_care) chk({v.name, ".WData"}, WData, v.exp_wd);
  endtask

  // Reference: derive RF write from the instruction semantics
  function automatic vec_t model(input vec_t v);
    logic [5:0] rd_fn[19] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09, 6'h10, 6'h12,
                              6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    logic [5:0] imm_op[8] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    vec_t r = v;
    int dest = -1;
    logic [5:0] op = v.ir[31:26];
    logic [5:0] fn = v.ir[5:0];
    logic [31:0] bytev = (v.dm >> (8 * v.alu[1:0])) & 32'hFF;
    logic [31:0] halfv = v.alu[1] ? (v.dm >> 16) : (v.dm & 32'hFFFF);
    logic [31:0] wd = v.alu;
    r.wd_care = 1'b1;
    if (v.rst || v.clr) begin
      r.exp_rw = 0; r.exp_a3 = 0; r.exp_wd = 0; r.exp_pcw = 32'hFFFF_FFF8;
      return r;
    end
    if (op == 6'h00) begin
      foreach (rd_fn[i]) if (fn == rd_fn[i]) dest = v.ir[15:11];
      if (fn == 6'h09) wd = v.pc8;
      if (fn == 6'h10 || fn == 6'h12) wd = v.md;
    end
    foreach (imm_op[i]) if (op == imm_op[i]) dest = v.ir[20:16];
    if (op == 6'h03) begin dest = 31; wd = v.pc8; end
    if (op == 6'h23) begin dest = v.ir[20:16]; wd = v.dm; end
    if (EXT) begin
      case (op)
        6'h20: begin dest = v.ir[20:16]; wd = (bytev ^ 32'h80) - 32'h80; end
        6'h24: begin dest = v.ir[20:16]; wd = bytev; end
        6'h21: begin dest = v.ir[20:16]; wd = (halfv ^ 32'h8000) - 32'h8000; end
        6'h25: begin dest = v.ir[20:16]; wd = halfv; end
        default: ;
      endcase
    end
    if (dest <= 0) begin
      r.exp_rw = 0; r.exp_a3 = 0; r.wd_care = 1'b0;
    end else begin
      r.exp_rw = 1; r.exp_a3 = dest[4:0];
    end
    r.exp_wd = wd;
    r.exp_pcw = v.pc8 - 32'd8;
    return r;
  endfunction

  initial begin
    logic [5:0] ops[18] = '{6'h00, 6'h00, 6'h00, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0d,
                            6'h0f, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2b, 6'h02, 6'h00};
    logic [5:0] fns[8] = '{6'h21, 6'h09, 6'h10, 6'h12, 6'h2a, 6'h00, 6'h08, 6'h18};
    vec_t v;

    reset = 1; clr = 0; IR_M = 0; PC8_M = 0; ALUOut_M = 0; DMRead_M = 0; MDOut_M = 0;

    //  name       rst clr ir            pc8           alu           dm            md            rw a3  wd            care
    add("reset",    1, 0, 32'h00221821, 32'h00003010, 32'h5,        32'h0,        32'h0,        0, 0,  32'h0,        1);
    add("addu",     0, 0, 32'h00221821, 32'h00003010, 32'h5,        32'h0,        32'h0,        1, 3,  32'h5,        1);
    add("rst_mid",  1, 0, 32'h00221821, 32'h00003014, 32'h6,        32'h0,        32'h0,        0, 0,  32'h0,        1);
    add("jal",      0, 0, 32'h0C000C00, 32'h00003008, 32'h1234,     32'h0,        32'h0,        1, 31, 32'h00003008, 1);
    add("lw",       0, 0, 32'h8C240000, 32'h0000300C, 32'h10,       32'h87654321, 32'h0,        1, 4,  32'h87654321, 1);
`ifdef WB_LOAD_EXT_EN
    add("lb_o0",    0, 0, 32'h80250000, 32'h00003010, 32'h20,       32'h876543F1, 32'h0,        1, 5,  32'hFFFFFFF1, 1);
    add("lbu_o3",   0, 0, 32'h90260000, 32'h00003014, 32'h23,       32'h876543F1, 32'h0,        1, 6,  32'h00000087, 1);
    add("lh_o2",    0, 0, 32'h84270000, 32'h00003018, 32'h22,       32'h876543F1, 32'h0,        1, 7,  32'hFFFF8765, 1);
    add("lhu_o1",   0, 0, 32'h94280000, 32'h0000301C, 32'h21,       32'h876543F1, 32'h0,        1, 8,  32'h000043F1, 1);
`else
    add("lb_off",   0, 0, 32'h80250000, 32'h00003010, 32'h20,       32'h876543F1, 32'h0,        0, 0,  32'h0,        0);
    add("lhu_off",  0, 0, 32'h94280000, 32'h0000301C, 32'h21,       32'h876543F1, 32'h0,        0, 0,  32'h0,        0);
`endif
    add("addiu_r0", 0, 0, 32'h24000007, 32'h00003020, 32'h7,        32'h0,        32'h0,        0, 0,  32'h0,        0);
    add("nop",      0, 0, 32'h00000000, 32'h00003024, 32'h0,        32'h0,        32'h0,        0, 0,  32'h0,        0);
    add("mflo",     0, 0, 32'h00004812, 32'h00003028, 32'h99,       32'h0,        32'hDEADBEEF, 1, 9,  32'hDEADBEEF, 1);
    add("mfhi",     0, 0, 32'h00005010, 32'h0000302C, 32'h99,       32'h0,        32'h01234567, 1, 10, 32'h01234567, 1);
    add("jalr",     0, 0, 32'h0040F809, 32'h00003030, 32'h99,       32'h0,        32'h0,        1, 31, 32'h00003030, 1);
    add("ori",      0, 0, 32'h340B00FF, 32'h00003034, 32'h000000FF, 32'h5555AAAA, 32'h0,        1, 11, 32'h000000FF, 1);
    add("sw",       0, 0, 32'hAC240000, 32'h00003038, 32'h40,       32'h0,        32'h0,        0, 0,  32'h0,        0);
    add("clr_addu", 0, 1, 32'h00221821, 32'h0000303C, 32'h5,        32'h0,        32'h0,        0, 0,  32'h0,        1);
    add("rst_clr",  1, 1, 32'h00221821, 32'h00003040, 32'h5,        32'h0,        32'h0,        0, 0,  32'h0,        1);

    for (int i = 0; i < vecs.size(); i++) run(vecs[i]);

    // Back-to-back instructions: each output reflects exactly the previous edge's inputs
    v = vecs[1]; v.name = "b2b_addu"; run(v);
    v = vecs[3]; v.name = "b2b_jal";  run(v);
    v = vecs[1]; v.name = "b2b_addu2"; v.alu = 32'hCAFEF00D; v.exp_wd = 32'hCAFEF00D; run(v);

    // Randomized instructions against the reference model
    for (int n = 0; n < 400; n++) begin
      v.rst = ($urandom_range(0, 31) == 0);
      v.clr = ($urandom_range(0, 15) == 0);
      v.ir  = $urandom;
      v.ir[31:26] = ops[$urandom_range(0, 17)];
      if (v.ir[31:26] == 6'h00) v.ir[5:0] = fns[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) v.ir[20:16] = 5'd0;
      if ($urandom_range(0, 7) == 0) v.ir[15:11] = 5'd0;
      v.pc8 = $urandom; v.alu = $urandom; v.dm = $urandom; v.md = $urandom;
      v = model(v);
      v.name = $sformatf("rand%0d", n);
      run(v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
